// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues/replays icache requests,
// buffers {pc, inst} pairs toward decode, applies backend redirects, counts fetches/misses.
module ifu_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ic_req,
    output logic [31:0] ic_pc,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] fetch_cnt,
    output logic [31:0] miss_cyc_cnt
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    logic [0:0]       state_q, state_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      fetch_cnt_q, fetch_cnt_d;
    logic [31:0]      miss_cnt_q, miss_cnt_d;
    fetch_entry_t     fifo_q [BUF_DEPTH];

    logic             hit_c;
    logic             miss_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic [31:0]      pc_inc_c;

    // Response classification and issue decision for the current cycle.
    always_comb begin
        hit_c      = (state_q == S_WAIT) && ic_valid && !redirect_valid;
        miss_c     = (state_q == S_WAIT) && !ic_valid && !redirect_valid;
        push_c     = hit_c;
        pop_c      = out_valid && out_ready && !redirect_valid;
        cnt_next_c = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        pc_inc_c   = req_pc_q + 32'd4;
        ic_pc      = hit_c ? pc_inc_c : req_pc_q;
        ic_req     = !rst && !redirect_valid && (cnt_next_c < DEPTH_C);
    end

    // Next-state logic; a redirect overrides response handling and flushes the buffer.
    always_comb begin
        state_d     = ic_req ? S_WAIT : S_IDLE;
        req_pc_d    = hit_c ? pc_inc_c : req_pc_q;
        count_d     = cnt_next_c;
        wr_ptr_d    = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fetch_cnt_d = fetch_cnt_q + 32'(hit_c);
        miss_cnt_d  = miss_cnt_q + 32'(miss_c);
        if (redirect_valid) begin
            state_d  = S_IDLE;
            req_pc_d = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_pc_q    <= RESET_PC;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_pc_q    <= req_pc_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Buffer storage; the pushed pc is the address that was outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push_c) begin
            fifo_q[wr_ptr_q] <= '{pc: req_pc_q, inst: ic_inst};
        end
    end

    assign out_valid    = (count_q != '0);
    assign out_pc       = fifo_q[rd_ptr_q].pc;
    assign out_inst     = fifo_q[rd_ptr_q].inst;
    assign fetch_cnt    = fetch_cnt_q;
    assign miss_cyc_cnt = miss_cnt_q;

`ifndef SYNTHESIS
    // The issue rule guarantees a response never lands in a full, non-draining buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push_c && (count_q == DEPTH_C) && !pop_c));
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference of the fetch stream.
`timescale 1ns/1ps
module tb_ifu_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_pc;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] fetch_cnt;
    logic [31:0] miss_cyc_cnt;

    int unsigned pass_cnt = 0;
    int unsigned tot_cnt  = 0;
    logic [31:0] ic_last_pc = 32'h0;

    ifu_fetch_ctrl #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_pc(ic_pc), .ic_valid(ic_valid), .ic_inst(ic_inst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .fetch_cnt(fetch_cnt), .miss_cyc_cnt(miss_cyc_cnt)
    );

    always #5 clk = ~clk;

    // Icache model: remembers the address requested last cycle.
    always @(posedge clk) if (ic_req) ic_last_pc <= ic_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC3A5_0F96;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit rv, input logic [31:0] rpc, input bit icv, input bit rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_valid       = icv;
        ic_inst        = icv ? inst_of(ic_last_pc) : $urandom;
        out_ready      = rdy;
        #1;
    endtask

    task automatic do_reset();
        next_cyc();
        rst = 1'b1;
        set_in(0, 32'h0, 0, 0);
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cyc();
        rst = 1'b1;
        set_in(0, 32'h0, 1, 1);
        next_cyc();
        tot_cnt++; if (ic_req !== 1'b0) $display("FAIL reset_ic_req got=%b exp=0", ic_req); else pass_cnt++;
        tot_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        tot_cnt++; if (fetch_cnt !== 32'h0) $display("FAIL reset_fetch_cnt got=%h exp=0", fetch_cnt); else pass_cnt++;
        tot_cnt++; if (miss_cyc_cnt !== 32'h0) $display("FAIL reset_miss_cnt got=%h exp=0", miss_cyc_cnt); else pass_cnt++;
        next_cyc();
        rst = 1'b0;
        #1;
        tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== RESET_PC)
            $display("FAIL reset_first_req got=%b/%h exp=1/%h", ic_req, ic_pc, RESET_PC); else pass_cnt++;
    endtask

    task automatic test_hits();
        logic [31:0] e_pc;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cyc();
            set_in(0, 32'h0, 1, 1);
            e_pc = RESET_PC + 32'(4 * k);
            tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== e_pc)
                $display("FAIL hits_ic_pc cyc=%0d got=%b/%h exp=1/%h", k, ic_req, ic_pc, e_pc); else pass_cnt++;
            tot_cnt++; if (out_valid !== (k >= 2))
                $display("FAIL hits_out_valid cyc=%0d got=%b exp=%b", k, out_valid, (k >= 2)); else pass_cnt++;
            if (k >= 2) begin
                e_pc = RESET_PC + 32'(4 * (k - 2));
                tot_cnt++; if (out_pc !== e_pc || out_inst !== inst_of(e_pc))
                    $display("FAIL hits_out cyc=%0d got=%h/%h exp=%h/%h", k, out_pc, out_inst, e_pc, inst_of(e_pc)); else pass_cnt++;
            end
            if (k >= 1) begin
                tot_cnt++; if (fetch_cnt !== 32'(k - 1))
                    $display("FAIL hits_fetch_cnt cyc=%0d got=%0d exp=%0d", k, fetch_cnt, k - 1); else pass_cnt++;
            end
        end
    endtask

    task automatic test_miss();
        bit icv_t [7] = '{1, 1, 0, 0, 0, 1, 1};
        int pc_t  [7] = '{0, 4, 4, 4, 4, 8, 12};
        bit ov_t  [7] = '{0, 0, 1, 0, 0, 0, 1};
        int opc_t [7] = '{0, 0, 0, 0, 0, 0, 4};
        int mc_t  [7] = '{0, 0, 0, 1, 2, 3, 3};
        logic [31:0] e_pc;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) next_cyc();
            set_in(0, 32'h0, icv_t[k], 1);
            e_pc = RESET_PC + 32'(pc_t[k]);
            tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== e_pc)
                $display("FAIL miss_ic_pc cyc=%0d got=%b/%h exp=1/%h", k, ic_req, ic_pc, e_pc); else pass_cnt++;
            tot_cnt++; if (out_valid !== ov_t[k])
                $display("FAIL miss_out_valid cyc=%0d got=%b exp=%b", k, out_valid, ov_t[k]); else pass_cnt++;
            if (ov_t[k]) begin
                e_pc = RESET_PC + 32'(opc_t[k]);
                tot_cnt++; if (out_pc !== e_pc)
                    $display("FAIL miss_out_pc cyc=%0d got=%h exp=%h", k, out_pc, e_pc); else pass_cnt++;
            end
            tot_cnt++; if (miss_cyc_cnt !== 32'(mc_t[k]))
                $display("FAIL miss_cnt cyc=%0d got=%0d exp=%0d", k, miss_cyc_cnt, mc_t[k]); else pass_cnt++;
        end
        tot_cnt++; if (fetch_cnt !== 32'd2) $display("FAIL miss_fetch_cnt got=%0d exp=2", fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit rdy_t [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        bit req_t [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int pc_t  [8] = '{0, 4, 8, 8, 8, 8, 12, 16};
        int opc_t [8] = '{0, 0, 0, 0, 0, 0, 4, 8};
        logic [31:0] e_pc;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cyc();
            set_in(0, 32'h0, 1, rdy_t[k]);
            tot_cnt++; if (ic_req !== req_t[k])
                $display("FAIL bp_ic_req cyc=%0d got=%b exp=%b", k, ic_req, req_t[k]); else pass_cnt++;
            e_pc = RESET_PC + 32'(pc_t[k]);
            tot_cnt++; if (ic_pc !== e_pc)
                $display("FAIL bp_ic_pc cyc=%0d got=%h exp=%h", k, ic_pc, e_pc); else pass_cnt++;
            tot_cnt++; if (out_valid !== (k >= 2))
                $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", k, out_valid, (k >= 2)); else pass_cnt++;
            if (k >= 2) begin
                e_pc = RESET_PC + 32'(opc_t[k]);
                tot_cnt++; if (out_pc !== e_pc || out_inst !== inst_of(e_pc))
                    $display("FAIL bp_out cyc=%0d got=%h/%h exp=%h/%h", k, out_pc, out_inst, e_pc, inst_of(e_pc)); else pass_cnt++;
            end
        end
        tot_cnt++; if (fetch_cnt !== 32'd3) $display("FAIL bp_fetch_cnt got=%0d exp=3", fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_redirect();
        do_reset();
        set_in(0, 32'h0, 1, 0);
        next_cyc(); set_in(0, 32'h0, 1, 0);
        tot_cnt++; if (ic_pc !== RESET_PC + 32'd4) $display("FAIL redir_pre_pc got=%h exp=%h", ic_pc, RESET_PC + 32'd4); else pass_cnt++;
        next_cyc(); set_in(1, 32'h0000_1000, 1, 0);
        tot_cnt++; if (ic_req !== 1'b0) $display("FAIL redir_req_low got=%b exp=0", ic_req); else pass_cnt++;
        tot_cnt++; if (out_valid !== 1'b1) $display("FAIL redir_buf_held got=%b exp=1", out_valid); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (out_valid !== 1'b0) $display("FAIL redir_flush got=%b exp=0", out_valid); else pass_cnt++;
        tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== 32'h0000_1000)
            $display("FAIL redir_target got=%b/%h exp=1/00001000", ic_req, ic_pc); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (out_valid !== 1'b0 || ic_pc !== 32'h0000_1004)
            $display("FAIL redir_second got=%b/%h exp=0/00001004", out_valid, ic_pc); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1000 || out_inst !== inst_of(32'h0000_1000))
            $display("FAIL redir_first_out got=%b/%h/%h exp=1/00001000/%h", out_valid, out_pc, out_inst, inst_of(32'h0000_1000)); else pass_cnt++;
        tot_cnt++; if (fetch_cnt !== 32'd2) $display("FAIL redir_fetch_cnt got=%0d exp=2", fetch_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(0, 32'h0, 1, 1);
        next_cyc(); set_in(0, 32'h0, 1, 1);
        next_cyc(); set_in(1, 32'h0000_2000, 1, 1);
        tot_cnt++; if (fetch_cnt !== 32'd1 || ic_req !== 1'b0)
            $display("FAIL b2b_hit_redir got=%0d/%b exp=1/0", fetch_cnt, ic_req); else pass_cnt++;
        next_cyc(); set_in(1, 32'h0000_3000, 0, 1);
        tot_cnt++; if (out_valid !== 1'b0 || ic_req !== 1'b0 || fetch_cnt !== 32'd1)
            $display("FAIL b2b_second got=%b/%b/%0d exp=0/0/1", out_valid, ic_req, fetch_cnt); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== 32'h0000_3000 || out_valid !== 1'b0)
            $display("FAIL b2b_last_wins got=%b/%h/%b exp=1/00003000/0", ic_req, ic_pc, out_valid); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_3000)
            $display("FAIL b2b_out got=%b/%h exp=1/00003000", out_valid, out_pc); else pass_cnt++;
    endtask

    task automatic test_wrap_reset();
        do_reset();
        set_in(1, 32'hFFFF_FFFC, 0, 1);
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (ic_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_issue got=%h exp=fffffffc", ic_pc); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== 32'h0) $display("FAIL wrap_pc got=%b/%h exp=1/00000000", ic_req, ic_pc); else pass_cnt++;
        next_cyc(); set_in(0, 32'h0, 0, 1);
        tot_cnt++; if (ic_pc !== 32'h0 || out_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_miss got=%h/%h exp=00000000/fffffffc", ic_pc, out_pc); else pass_cnt++;
        next_cyc();
        rst = 1'b1;
        set_in(0, 32'h0, 0, 1);
        tot_cnt++; if (ic_req !== 1'b0 || miss_cyc_cnt !== 32'd1)
            $display("FAIL midmiss_rst got=%b/%0d exp=0/1", ic_req, miss_cyc_cnt); else pass_cnt++;
        next_cyc();
        rst = 1'b0;
        set_in(0, 32'h0, 1, 1);
        tot_cnt++; if (ic_req !== 1'b1 || ic_pc !== RESET_PC || out_valid !== 1'b0)
            $display("FAIL postrst_req got=%b/%h/%b exp=1/%h/0", ic_req, ic_pc, out_valid, RESET_PC); else pass_cnt++;
        tot_cnt++; if (fetch_cnt !== 32'h0 || miss_cyc_cnt !== 32'h0)
            $display("FAIL postrst_cnt got=%0d/%0d exp=0/0", fetch_cnt, miss_cyc_cnt); else pass_cnt++;
    endtask

    // Reference: pending flag, next fetch address, queue of buffered PCs, event totals.
    task automatic test_random();
        logic [31:0] q [$];
        logic [31:0] m_pc, s_pc, rpc, e_pc;
        logic [31:0] m_fetch, m_miss;
        bit m_pend, rv, icv, rdy, m_hit, m_miss_ev, m_pop, e_req;
        int occ;
        do_reset();
        m_pc = RESET_PC; s_pc = RESET_PC; m_pend = 0; m_fetch = 0; m_miss = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i > 0) next_cyc();
            rv  = ($urandom_range(15) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            icv = ($urandom_range(3) != 0);
            rdy = ($urandom_range(2) != 0);
            set_in(rv, rpc, icv, rdy);
            m_hit     = m_pend && !rv && icv;
            m_miss_ev = m_pend && !rv && !icv;
            m_pop     = (q.size() != 0) && rdy && !rv;
            occ       = q.size() + int'(m_hit) - int'(m_pop);
            e_req     = !rv && (occ < DEPTH);
            e_pc      = m_hit ? m_pc + 32'd4 : m_pc;
            tot_cnt++; if (ic_req !== e_req) $display("FAIL rnd_ic_req cyc=%0d got=%b exp=%b", i, ic_req, e_req); else pass_cnt++;
            tot_cnt++; if (ic_pc !== e_pc) $display("FAIL rnd_ic_pc cyc=%0d got=%h exp=%h", i, ic_pc, e_pc); else pass_cnt++;
            tot_cnt++; if (out_valid !== (q.size() != 0))
                $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, (q.size() != 0)); else pass_cnt++;
            if (q.size() != 0) begin
                tot_cnt++; if (out_pc !== q[0] || out_inst !== inst_of(q[0]))
                    $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, out_pc, out_inst, q[0], inst_of(q[0])); else pass_cnt++;
            end
            if (m_pop) begin
                tot_cnt++; if (out_pc !== s_pc) $display("FAIL rnd_stream cyc=%0d got=%h exp=%h", i, out_pc, s_pc); else pass_cnt++;
                s_pc = s_pc + 32'd4;
            end
            tot_cnt++; if (fetch_cnt !== m_fetch || miss_cyc_cnt !== m_miss)
                $display("FAIL rnd_counters cyc=%0d got=%0d/%0d exp=%0d/%0d", i, fetch_cnt, miss_cyc_cnt, m_fetch, m_miss); else pass_cnt++;
            if (rv) begin
                q.delete();
                m_pc = rpc; s_pc = rpc; m_pend = 0;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_hit) begin
                    q.push_back(m_pc);
                    m_fetch = m_fetch + 32'd1;
                    m_pc = m_pc + 32'd4;
                end
                if (m_miss_ev) m_miss = m_miss + 32'd1;
                m_pend = e_req;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        ic_valid = 1'b0; ic_inst = 32'h0; out_ready = 1'b0;
        test_reset();
        test_hits();
        test_miss();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
